// File: rtl/booth_radix4_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_pkg
// Purpose  : Shared definitions for the radix-4 Booth multiplier:
//            FSM state encoding, Booth digit encoding and the helper that
//            derives the radix-4 digit count from the operand width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

  // FSM states. Encoding 2'd3 is never entered and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth radix-4 digit values.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_t;

  // The multiplier is extended by two bits before recoding, so an N-bit
  // operand yields N/2+1 radix-4 digits.
  function automatic int calc_iters(input int input_bits);
    return input_bits / 2 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_radix4_encoder.sv
`default_nettype none
// ============================================================================
// Module   : booth_radix4_encoder
// Purpose  : Combinational radix-4 Booth recoder. Maps the triplet
//            {m[i+1], m[i], m[i-1]} to a digit in {0, +1, +2, -1, -2}.
// Ports    : triplet - 3-bit window of the multiplier (guard in bit 0)
//            digit   - decoded Booth digit
//            sel_2x  - magnitude is 2 (use multiplicand shifted left by 1)
//            negate  - digit is negative (subtract the partial product)
// Revision : 1.0 - initial release
// ============================================================================
module booth_radix4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] triplet,
  output digit_t     digit,
  output logic       sel_2x,
  output logic       negate
);

  always_comb begin
    digit  = ZERO;
    sel_2x = 1'b0;
    negate = 1'b0;
    case (triplet)
      3'b001, 3'b010: digit = POS1;
      3'b011: begin
        digit  = POS2;
        sel_2x = 1'b1;
      end
      3'b100: begin
        digit  = NEG2;
        sel_2x = 1'b1;
        negate = 1'b1;
      end
      3'b101, 3'b110: begin
        digit  = NEG1;
        negate = 1'b1;
      end
      default: digit = ZERO;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/booth_radix4_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : booth_radix4_multiplier
// Purpose  : Iterative radix-4 Booth multiplier, two multiplier bits retired
//            per cycle, per-transaction signed/unsigned mode, valid/ready
//            handshakes on input and output with output hold.
//            Optional macro BOOTH_EARLY_TERMINATION_EN: finish as soon as all
//            remaining Booth digits are zero (data-dependent latency,
//            bit-identical products).
// Ports    : CLK, RST          - clock, synchronous active-high reset
//            IN_VALID/IN_READY - operand handshake (MUL_1, MUL_2, SIGNED_MODE)
//            OUT_VALID/OUT_READY - product handshake (MUL_OUT)
//            STATE             - current FSM state for observability
// Revision : 1.0 - initial release
// ============================================================================
module booth_radix4_multiplier
  import booth_pkg::*;
#(
  parameter int INPUT_BITS = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [INPUT_BITS-1:0]     MUL_1,
  input  logic [INPUT_BITS-1:0]     MUL_2,
  input  logic                      SIGNED_MODE,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [2*INPUT_BITS-1:0]   MUL_OUT,
  output logic [1:0]                STATE
);

  localparam int OUTPUT_BITS = 2 * INPUT_BITS;
  localparam int ITERS       = calc_iters(INPUT_BITS);
  localparam int EXT_BITS    = INPUT_BITS + 2;
  localparam int CNT_W       = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  state_t                 state_q, state_d;
  logic [OUTPUT_BITS-1:0] mcand_q;
  logic [OUTPUT_BITS-1:0] acc_q;
  logic [OUTPUT_BITS-1:0] mul_out_q;
  logic [EXT_BITS-1:0]    mplier_q;
  logic                   guard_q;
  logic [CNT_W-1:0]       cnt_q;

  logic                   accept;
  logic                   last_iter;
  logic                   ext_1;
  logic                   ext_2;
  digit_t                 digit;
  logic                   sel_2x;
  logic                   negate;
  logic [OUTPUT_BITS-1:0] pp_mag;
  logic [OUTPUT_BITS-1:0] acc_next;

  booth_radix4_encoder u_encoder (
    .triplet ({mplier_q[1:0], guard_q}),
    .digit   (digit),
    .sel_2x  (sel_2x),
    .negate  (negate)
  );

  // Partial-product select and add/subtract; wraps modulo 2^OUTPUT_BITS.
  always_comb begin
    pp_mag = sel_2x ? {mcand_q[OUTPUT_BITS-2:0], 1'b0} : mcand_q;
    if (digit == ZERO) begin
      pp_mag = '0;
    end
    acc_next = negate ? (acc_q - pp_mag) : (acc_q + pp_mag);
  end

`ifdef BOOTH_EARLY_TERMINATION_EN
  // After this step the multiplier shifts arithmetically and the new guard is
  // m[1]; if m[EXT_BITS-1:1] is uniform, every later triplet is 000 or 111.
  logic zero_tail;
  assign zero_tail = (mplier_q[EXT_BITS-1:1] == '0) || (mplier_q[EXT_BITS-1:1] == '1);
  assign last_iter = (cnt_q == LAST_ITER) || zero_tail;
`else
  assign last_iter = (cnt_q == LAST_ITER);
`endif

  assign accept = IN_VALID && (state_q == IDLE);
  assign ext_1  = SIGNED_MODE & MUL_1[INPUT_BITS-1];
  assign ext_2  = SIGNED_MODE & MUL_2[INPUT_BITS-1];

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state_q)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge CLK) begin
    if (RST) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      guard_q   <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mul_out_q <= '0;
    end else if (accept) begin
      mcand_q  <= {{INPUT_BITS{ext_1}}, MUL_1};
      mplier_q <= {{2{ext_2}}, MUL_2};
      guard_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == BUSY) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 2;
      mplier_q <= {{2{mplier_q[EXT_BITS-1]}}, mplier_q[EXT_BITS-1:2]};
      guard_q  <= mplier_q[1];
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last_iter) begin
        mul_out_q <= acc_next;
      end
    end
  end

  assign MUL_OUT = mul_out_q;
  assign STATE   = state_q;

endmodule
`default_nettype wire
